// File: rtl/dmem_port_arbiter.sv
// Arbitrates one byte-wide data memory between a CPU port and a DMA port.
// Each granted word access runs as four big-endian byte beats followed by a done cycle.
module dmem_port_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_done_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_done_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   state_t              state_q, state_d;
   logic [1:0]          k_q, k_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rbuf_q, rbuf_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                sel;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q     <= IDLE;
         k_q         <= '0;
         owner_q     <= OWN_CPU;
         last_q      <= OWN_DMA;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rbuf_q      <= rbuf_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      owner_d     = owner_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      cpu_gnt_o   = 1'b0;
      dma_gnt_o   = 1'b0;
      cpu_done_o  = 1'b0;
      dma_done_o  = 1'b0;
      sel         = OWN_CPU;

      unique case (state_q)
         IDLE: begin
            if (cpu_req_i || dma_req_i) begin
               // On a tie the requester not served last wins.
               sel     = (cpu_req_i && (!dma_req_i || last_q == OWN_DMA)) ? OWN_CPU : OWN_DMA;
               owner_d = sel;
               last_d  = sel;
               we_d    = (sel == OWN_CPU) ? cpu_we_i    : dma_we_i;
               addr_d  = (sel == OWN_CPU) ? cpu_addr_i  : dma_addr_i;
               wdata_d = (sel == OWN_CPU) ? cpu_wdata_i : dma_wdata_i;
               k_d     = 2'd0;
               state_d = BEAT;
            end
         end
         BEAT: begin
            cpu_gnt_o  = (owner_q == OWN_CPU);
            dma_gnt_o  = (owner_q == OWN_DMA);
            mem_addr_o = addr_q + ADDR_W'(k_q);
            // Gated by reset so an abort blocks the byte of the current beat too.
            mem_we_o   = we_q && !reset_i;
            if (we_q) begin
               unique case (k_q)
                  2'd0: mem_wdata_o = wdata_q[DATA_W-1  -: 8];
                  2'd1: mem_wdata_o = wdata_q[DATA_W-9  -: 8];
                  2'd2: mem_wdata_o = wdata_q[DATA_W-17 -: 8];
                  default: mem_wdata_o = wdata_q[DATA_W-25 -: 8];
               endcase
            end else begin
               unique case (k_q)
                  2'd0: rbuf_d[DATA_W-1  -: 8] = mem_rdata_i;
                  2'd1: rbuf_d[DATA_W-9  -: 8] = mem_rdata_i;
                  2'd2: rbuf_d[DATA_W-17 -: 8] = mem_rdata_i;
                  default: rbuf_d[DATA_W-25 -: 8] = mem_rdata_i;
               endcase
            end
            if (k_q == 2'd3) begin
               // Publish the assembled word so it is valid alongside done.
               if (!we_q) begin
                  if (owner_q == OWN_CPU) cpu_rdata_d = {rbuf_q[DATA_W-1:8], mem_rdata_i};
                  else                    dma_rdata_d = {rbuf_q[DATA_W-1:8], mem_rdata_i};
               end
               state_d = DONE;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         DONE: begin
            cpu_gnt_o  = (owner_q == OWN_CPU);
            dma_gnt_o  = (owner_q == OWN_DMA);
            cpu_done_o = (owner_q == OWN_CPU);
            dma_done_o = (owner_q == OWN_DMA);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign dma_rdata_o = dma_rdata_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 32-byte memory model driven from the
// arbiter's byte port; expected values are hand-computed per scenario.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_gnt, dma_done;
   logic [4:0]  dma_addr;
   logic [31:0] dma_wdata, dma_rdata;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        busy;

   logic [7:0]  mem [32];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          we_cnt   = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   dmem_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .reset_i(reset),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_gnt_o(cpu_gnt), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
      .dma_gnt_o(dma_gnt), .dma_done_o(dma_done), .dma_rdata_o(dma_rdata),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .busy_o(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Memory write strobes are sampled mid-cycle and committed at the following posedge.
   task automatic tick();
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
      @(negedge clk);
      w = mem_we; a = mem_addr; d = mem_wdata;
      if (w) we_cnt++;
      @(posedge clk);
      if (w) mem[a] = d;
      #1;
   endtask

   task automatic run(input bit is_dma, input bit we, input logic [4:0] a, input logic [31:0] wd,
                      output int cyc, output int gnt_cyc);
      logic dn;
      if (is_dma) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd; end
      else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
      cyc = 0; gnt_cyc = 0; dn = 1'b0;
      while (!dn && cyc < 20) begin
         tick();
         cyc++;
         if (is_dma ? dma_gnt : cpu_gnt) gnt_cyc++;
         dn = is_dma ? dma_done : cpu_done;
      end
      if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
      $display("txn %s we=%0d addr=%0d wdata=%08h cycles=%0d", is_dma ? "DMA" : "CPU", we, a, wd, cyc);
   endtask

   initial begin
      int cyc, gcyc, dones;
      int      t;
      int      order[$];
      int      times[$];

      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[8] = 8'hA1; mem[9] = 8'hB2; mem[10] = 8'hC3; mem[11] = 8'hD4;
      mem[16] = 8'h01; mem[17] = 8'h02; mem[18] = 8'h03; mem[19] = 8'h04;
      mem[20] = 8'h55; mem[21] = 8'h66; mem[22] = 8'h77; mem[23] = 8'h88;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;

      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
      check("rst_done", {30'd0, cpu_done, dma_done}, 32'd0);
      check("rst_mem", {18'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_dma_rdata", dma_rdata, 32'd0);

      // Simultaneous requests held high: CPU first, then strict alternation, 6-cycle spacing.
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'd16;
      dma_req = 1; dma_we = 0; dma_addr = 5'd8;
      t = 0;
      while (order.size() < 4 && t < 60) begin
         tick();
         t++;
         if (cpu_done) begin
            order.push_back(0); times.push_back(t);
            check("tie_cpu_rdata", cpu_rdata, 32'h01020304);
         end
         if (dma_done) begin
            order.push_back(1); times.push_back(t);
            check("tie_dma_rdata", dma_rdata, 32'hA1B2C3D4);
         end
      end
      cpu_req = 0; dma_req = 0;
      check("tie_count", order.size(), 4);
      for (int i = 0; i < order.size() && i < 4; i++) begin
         check($sformatf("tie_order%0d", i), order[i], i % 2);
         check($sformatf("tie_time%0d", i), times[i], 5 + 6 * i);
         $display("txn tie %0d owner=%s done_at=%0d", i, order[i] ? "DMA" : "CPU", times[i]);
      end
      tick();
      check("tie_idle", {31'd0, busy}, 32'd0);

      // CPU write 0xDEADBEEF at 4.
      we_cnt = 0;
      run(0, 1, 5'd4, 32'hDEADBEEF, cyc, gcyc);
      check("wr_latency", cyc, 5);
      check("wr_gnt_cycles", gcyc, 5);
      check("wr_strobes", we_cnt, 4);
      check("wr_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
      check("wr_rdata_kept", cpu_rdata, 32'h01020304);
      tick();
      check("wr_done_pulse", {30'd0, cpu_done, cpu_gnt}, 32'd0);

      // CPU read back from 4.
      we_cnt = 0;
      run(0, 0, 5'd4, 32'h0, cyc, gcyc);
      check("rd_latency", cyc, 5);
      check("rd_rdata", cpu_rdata, 32'hDEADBEEF);
      check("rd_no_strobe", we_cnt, 0);
      tick();

      // DMA write wrapping past the top of memory.
      run(1, 1, 5'd30, 32'h11223344, cyc, gcyc);
      check("wrap_latency", cyc, 5);
      check("wrap_bytes", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
      check("wrap_byte2", {24'd0, mem[2]}, 32'd0);
      check("wrap_dma_rdata_kept", dma_rdata, 32'hA1B2C3D4);
      tick();

      // Address changed right after acceptance is ignored.
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'd4;
      tick();
      cpu_addr = 5'd20;
      cyc = 1;
      while (!cpu_done && cyc < 20) begin tick(); cyc++; end
      cpu_req = 0;
      $display("txn CPU addr-change read cycles=%0d rdata=%08h", cyc, cpu_rdata);
      check("addr_hold_latency", cyc, 5);
      check("addr_hold_rdata", cpu_rdata, 32'hDEADBEEF);
      tick();

      // Reset during beat 1 of a write aborts it after byte 0.
      we_cnt = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'd12; cpu_wdata = 32'hAABBCCDD;
      tick();
      tick();
      reset = 1'b1; cpu_req = 0;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_gnt", {31'd0, cpu_gnt}, 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cpu_done || dma_done) dones++;
      end
      $display("txn CPU aborted write addr=12 strobes=%0d", we_cnt);
      check("abort_no_done", dones, 0);
      check("abort_strobes", we_cnt, 1);
      check("abort_bytes", {mem[12], mem[13], mem[14], mem[15]}, 32'hAA000000);
      check("abort_rdata_reset", cpu_rdata, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
